// File: rtl/pipebomb_fifo_pkg.sv
// Shared types and sizing helpers for the pipebomb datapath FIFOs.
package pipebomb_fifo_pkg;

    typedef logic [127:0] msg_t;

    localparam int STATS_W = 32;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/msg_queue_ptr.sv
// Wrapping read/write pointer for msg_queue; wraps DEPTH-1 -> 0 without modulo.
module msg_queue_ptr #(
    parameter int DEPTH = 16,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/msg_queue.sv
// Single-clock show-ahead message FIFO with level flags, flush and drop-on-full mode.
// Define MSG_QUEUE_STATS_EN to add the drop_cnt / hwm statistics ports.
module msg_queue
    import pipebomb_fifo_pkg::*;
#(
    parameter type T             = msg_t,
    parameter int  DEPTH         = 16,
    parameter int  AFULL_THRESH  = DEPTH - 2,
    parameter int  AEMPTY_THRESH = 1,
    parameter bit  DROP_ON_FULL  = 1'b0,
    localparam int LW            = level_width(DEPTH),
    localparam int PW            = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          in_v,
    output logic          in_r,
    input  T              in_d,
    output logic          out_v,
    input  logic          out_r,
    output T              out_d,
    output logic [LW-1:0] level,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow
`ifdef MSG_QUEUE_STATS_EN
    ,
    output logic [STATS_W-1:0] drop_cnt,
    output logic [LW-1:0]      hwm
`endif
);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [LW-1:0] level_next;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          refused;

    // Flags come from the level register only, so in_r never depends on out_r.
    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign in_r    = DROP_ON_FULL ? 1'b1 : !full;
    assign push    = in_v && !full && !flush;
    assign pop     = out_v && out_r && !flush;
    assign refused = in_v && full && !flush;

    assign out_v        = !empty;
    assign out_d        = mem[rptr];
    assign almost_full  = (int'(level) >= AFULL_THRESH);
    assign almost_empty = (int'(level) <= AEMPTY_THRESH);

    msg_queue_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk  (clk),
        .rstn (rstn),
        .clr  (flush),
        .inc  (push),
        .ptr  (wptr)
    );

    msg_queue_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk  (clk),
        .rstn (rstn),
        .clr  (flush),
        .inc  (pop),
        .ptr  (rptr)
    );

    // NOTE: the payload array has no reset; out_v hides stale entries and a reset would prevent RAM mapping.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_d;
        end
    end

    // NOTE: level_next gets a default first so no path through this block infers a latch.
    always_comb begin
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            level    <= level_next;
            overflow <= refused;
        end
    end

`ifdef MSG_QUEUE_STATS_EN
    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= '0;
            hwm      <= '0;
        end else begin
            if (refused && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + STATS_W'(1);
            end
            if (level_next > hwm) begin
                hwm <= level_next;
            end
        end
    end
`endif

endmodule
